// File: rtl/reg_write_sequencer.sv
// reg_write_sequencer
// Write-side controller for the latch-based CPU register file. A single-cycle request
// (register index plus 16-bit value) is turned into a DIN/W waveform with programmable
// setup, strobe and hold lengths. The written register is then read back and compared.
//
// Ports:
//   CLK       rising-edge system clock
//   RST       asynchronous active-high reset
//   REQ       write request, sampled only in IDLE
//   ADDR      target register index, sampled with REQ
//   DATA      value to write, sampled with REQ
//   DOUT_ALL  register outputs, register i at [16i+15:16i]
//   DIN       shared data bus to the registers
//   W         one-hot write strobes
//   BUSY      sequence in progress (SETUP..HOLD)
//   DONE      single-cycle completion pulse
//   ERR       readback mismatch or out-of-range ADDR, valid from DONE to next accept
module reg_write_sequencer #(
   parameter int unsigned NUM_REGS     = 8,
   parameter int unsigned SETUP_CYCLES = 1,
   parameter int unsigned PULSE_CYCLES = 1,
   parameter int unsigned HOLD_CYCLES  = 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     REQ,
   input  logic [3:0]               ADDR,
   input  logic [15:0]              DATA,
   input  logic [16*NUM_REGS-1:0]   DOUT_ALL,
   output logic [15:0]              DIN,
   output logic [NUM_REGS-1:0]      W,
   output logic                     BUSY,
   output logic                     DONE,
   output logic                     ERR
);

   typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StFin} state_e;

   localparam logic [7:0] SetupLd  = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] PulseLd  = 8'(PULSE_CYCLES - 1);
   localparam logic [7:0] HoldLd   = 8'(HOLD_CYCLES - 1);
   localparam logic [4:0] NumRegsW = 5'(NUM_REGS);

   state_e                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [3:0]            addr_q, addr_d;
   logic [15:0]           din_q, din_d;
   logic [NUM_REGS-1:0]   w_q, w_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [15:0]           rd_data;
   logic                  addr_ok;

   // Readback mux; an out-of-range index reads as zero and is flagged through addr_ok.
   always_comb begin
      rd_data = 16'h0000;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (addr_q == 4'(i)) rd_data = DOUT_ALL[16*i +: 16];
      end
      addr_ok = ({1'b0, addr_q} < NumRegsW);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      din_d   = din_q;
      err_d   = err_q;

      unique case (state_q)
         StIdle: begin
            if (REQ) begin
               addr_d  = ADDR;
               din_d   = DATA;
               cnt_d   = SetupLd;
               err_d   = 1'b0;
               state_d = StSetup;
            end
         end
         StSetup: begin
            if (cnt_q == 8'd0) begin
               cnt_d   = PulseLd;
               state_d = StPulse;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StPulse: begin
            if (cnt_q == 8'd0) begin
               cnt_d   = HoldLd;
               state_d = StHold;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StHold: begin
            if (cnt_q == 8'd0) begin
               // Register holds the written value by the last hold cycle.
               err_d   = !addr_ok || (rd_data != din_q);
               state_d = StFin;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are decoded from the next state so they are registered, glitch-free.
      busy_d = (state_d == StSetup) || (state_d == StPulse) || (state_d == StHold);
      done_d = (state_d == StFin);
      w_d    = '0;
      if (state_d == StPulse) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            w_d[i] = (addr_q == 4'(i));
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
         addr_q  <= 4'd0;
         din_q   <= 16'h0000;
         w_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         w_q     <= w_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign DIN  = din_q;
   assign W    = w_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
   assign ERR  = err_q;

endmodule

// File: tb/tb_reg_write_sequencer.sv
module tb_reg_write_sequencer;

   logic CLK;
   logic RST;

   // Instance A: default timing, 8 registers.
   logic          req_a;
   logic [3:0]    addr_a;
   logic [15:0]   data_a;
   logic [127:0]  dout_a;
   logic [15:0]   din_a;
   logic [7:0]    w_a;
   logic          busy_a, done_a, err_a;

   // Instance B: S=3, P=2, H=4.
   logic          req_b;
   logic [3:0]    addr_b;
   logic [15:0]   data_b;
   logic [127:0]  dout_b;
   logic [15:0]   din_b;
   logic [7:0]    w_b;
   logic          busy_b, done_b, err_b;

   logic [15:0] regs_a [8] = '{default: 16'h0000};
   logic [15:0] regs_b [8] = '{default: 16'h0000};
   logic        model_en_a;

   int total = 0;
   int bad   = 0;

   reg_write_sequencer dut_a (
      .CLK      (CLK),
      .RST      (RST),
      .REQ      (req_a),
      .ADDR     (addr_a),
      .DATA     (data_a),
      .DOUT_ALL (dout_a),
      .DIN      (din_a),
      .W        (w_a),
      .BUSY     (busy_a),
      .DONE     (done_a),
      .ERR      (err_a)
   );

   reg_write_sequencer #(
      .NUM_REGS     (8),
      .SETUP_CYCLES (3),
      .PULSE_CYCLES (2),
      .HOLD_CYCLES  (4)
   ) dut_b (
      .CLK      (CLK),
      .RST      (RST),
      .REQ      (req_b),
      .ADDR     (addr_b),
      .DATA     (data_b),
      .DOUT_ALL (dout_b),
      .DIN      (din_b),
      .W        (w_b),
      .BUSY     (busy_b),
      .DONE     (done_b),
      .ERR      (err_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Register file model: a strobed register captures DIN while its strobe is high.
   always @(posedge CLK) begin
      for (int i = 0; i < 8; i++) begin
         if (model_en_a && w_a[i]) regs_a[i] <= din_a;
         if (w_b[i]) regs_b[i] <= din_b;
      end
   end

   always_comb begin
      dout_a = '0;
      dout_b = '0;
      for (int i = 0; i < 8; i++) begin
         dout_a[16*i +: 16] = regs_a[i];
         dout_b[16*i +: 16] = regs_b[i];
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One full default-timing sequence on instance A, cycles 1..5 checked.
   task automatic seq_a(input logic [3:0] a, input logic [15:0] d, input logic [7:0] ew,
                        input logic ee);
      addr_a = a;
      data_a = d;
      req_a  = 1'b1;
      tick();
      req_a  = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         chk("a_din", 32'(din_a), 32'(d));
         chk("a_w", 32'(w_a), (n == 2) ? 32'(ew) : 32'd0);
         chk("a_busy", 32'(busy_a), (n <= 3) ? 32'd1 : 32'd0);
         chk("a_done", 32'(done_a), (n == 4) ? 32'd1 : 32'd0);
         chk("a_err", 32'(err_a), (n >= 4) ? 32'(ee) : 32'd0);
         tick();
      end
   endtask

   initial begin
      RST        = 1'b1;
      req_a      = 1'b0;
      addr_a     = 4'd0;
      data_a     = 16'h0000;
      req_b      = 1'b0;
      addr_b     = 4'd0;
      data_b     = 16'h0000;
      model_en_a = 1'b1;
      #1;
      chk("rst_din", 32'(din_a), 32'h0);
      chk("rst_w", 32'(w_a), 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_done", 32'(done_a), 32'h0);
      chk("rst_err", 32'(err_a), 32'h0);
      tick();
      tick();
      RST = 1'b0;
      tick();

      // Basic write with readback.
      seq_a(4'd3, 16'hA5A5, 8'h08, 1'b0);
      chk("model_r3", 32'(regs_a[3]), 32'hA5A5);

      // Register ignores the strobe: readback mismatch, then ERR clears on next accept.
      model_en_a = 1'b0;
      seq_a(4'd5, 16'h1234, 8'h20, 1'b1);
      model_en_a = 1'b1;
      seq_a(4'd2, 16'h5A5A, 8'h04, 1'b0);

      // Out-of-range index: no strobe, ERR set.
      seq_a(4'd9, 16'h7777, 8'h00, 1'b1);
      seq_a(4'd1, 16'h0001, 8'h02, 1'b0);

      // Longer timing on instance B.
      addr_b = 4'd0;
      data_b = 16'hFFFF;
      req_b  = 1'b1;
      tick();
      req_b  = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         chk("b_w", 32'(w_b), (n == 4 || n == 5) ? 32'h1 : 32'h0);
         if (n <= 9) chk("b_din", 32'(din_b), 32'hFFFF);
         chk("b_busy", 32'(busy_b), (n <= 9) ? 32'd1 : 32'd0);
         chk("b_done", 32'(done_b), (n == 10) ? 32'd1 : 32'd0);
         if (n == 10) chk("b_err", 32'(err_b), 32'd0);
         tick();
      end

      // REQ held high: accepts every 5 edges.
      addr_a = 4'd1;
      data_a = 16'h0F0F;
      req_a  = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         tick();
         chk("hold_busy", 32'(busy_a), (t % 5 >= 1 && t % 5 <= 3) ? 32'd1 : 32'd0);
         chk("hold_done", 32'(done_a), (t % 5 == 4) ? 32'd1 : 32'd0);
      end
      req_a = 1'b0;
      tick();

      // REQ pulses during PULSE and FIN are ignored.
      addr_a = 4'd6;
      data_a = 16'h00FF;
      req_a  = 1'b1;
      tick();
      req_a  = 1'b0;
      tick();
      req_a  = 1'b1;
      tick();
      req_a  = 1'b0;
      tick();
      chk("ign_done", 32'(done_a), 32'd1);
      req_a  = 1'b1;
      tick();
      chk("ign_busy5", 32'(busy_a), 32'd0);
      chk("ign_done5", 32'(done_a), 32'd0);
      req_a  = 1'b0;
      tick();
      chk("ign_busy6", 32'(busy_a), 32'd0);

      // Asynchronous reset during PULSE.
      addr_a = 4'd4;
      data_a = 16'hBEEF;
      req_a  = 1'b1;
      tick();
      req_a  = 1'b0;
      tick();
      chk("ar_w_pre", 32'(w_a), 32'h10);
      #2;
      RST = 1'b1;
      #1;
      chk("ar_w", 32'(w_a), 32'h0);
      chk("ar_busy", 32'(busy_a), 32'h0);
      chk("ar_din", 32'(din_a), 32'h0);
      tick();
      RST = 1'b0;
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("ar_nodone", 32'(done_a), 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
